board_reader: RTL and testbench
===============================

BOARD_READER -- requirements
Module: board_reader

Interface
REQ-001 Parameter CELLS, 64, number of board cells (8x8).
REQ-002 Parameter CELL_W, 3, bits per cell in the packed board vector.
REQ-003 Port clk  input  1  single clock; all state updates on rising edge.
REQ-004 Port reset  input  1  asynchronous, active-high reset.
REQ-005 Port start  input  1  request a full scan of curr_board; honoured only when ready=1.
REQ-006 Port curr_board  input  CELLS*CELL_W (192)  packed board; cell i occupies bits [3i+2:3i], i = y*8+x.
REQ-007 Port ready  output  1  high while idle and able to accept start.
REQ-008 Port cell_valid  output  1  cell_index/cell_x/cell_y/cell_state hold a valid cell.
REQ-009 Port cell_ack  input  1  consumer accepts the presented cell this cycle.
REQ-010 Port cell_index  output  6  index of presented cell.
REQ-011 Port cell_x / cell_y  output  3 each  cell_index[2:0] / cell_index[5:3].
REQ-012 Port cell_state  output  2  decoded cell: 00 empty, 01 white, 10 black, 11 illegal code.
REQ-013 Port done  output  1  one-cycle pulse after the last cell is accepted.
REQ-014 Port black_count / white_count / empty_count  output  7 each  totals for the most recent scan.

Function
REQ-015 Cell decode: 3'b111 -> black, 3'b110 -> white, 3'b000 -> empty; every other code -> illegal (11), counted in none of the three totals.
REQ-016 FSM states IDLE, SCAN, DONE; IDLE->SCAN on start with ready=1; SCAN->DONE when cell 63 is presented and cell_ack=1; DONE->IDLE unconditionally after one cycle.
REQ-017 On the accepted start edge, curr_board is snapshotted into an internal register; later curr_board changes do not affect the scan in progress.
REQ-018 On the accepted start edge, all three counts clear to 0 and cell_index loads 0.
REQ-019 Latency: start accepted at edge N -> cell_valid=1 with cell 0 from edge N onward (visible the cycle after start is sampled).
REQ-020 In SCAN, cell_valid=1 continuously; presented outputs hold stable while cell_ack=0 (stall, no limit on duration).
REQ-021 On each edge with cell_valid=1 and cell_ack=1, the matching count increments by 1 and cell_index advances by 1.
REQ-022 cell_ack while cell_valid=0 has no effect.
REQ-023 ready=1 only in IDLE; start in SCAN or DONE is ignored, not queued.
REQ-024 done=1 for exactly the DONE cycle; counts are final from that cycle and hold until the next accepted start.
REQ-025 Invariant at done: black_count+white_count+empty_count+illegal cells = 64; all-one-type board yields 64 (7-bit, no overflow).
REQ-026 cell_index does not wrap during a scan; after cell 63 is accepted it returns to 0 on entry to IDLE.

Reset
REQ-027 reset asserted (any time, including mid-scan) forces IDLE immediately: ready=1, cell_valid=0, done=0, cell_index=0, all counts 0, snapshot cleared to all zeros.
REQ-028 A start sampled while reset is high is ignored; the first accepted start is on the first edge after reset deasserts.

Structure
REQ-029 Shared package board_pkg SHALL hold CELLS, CELL_W, cell codes CELL_BLACK=3'b111, CELL_WHITE=3'b110, CELL_EMPTY=3'b000, and the 2-bit decoded-state constants.
REQ-030 FSM state encoding SHALL stay local to board_reader.
REQ-031 One combinational sub-module cell_decode (3-bit code -> 2-bit cell_state) SHALL be instantiated; it is reused by other board consumers.

Verification
REQ-032 All-zero board, start, cell_ack tied 1 -> 64 valid cells, done on the cycle after cell 63 is accepted, empty=64, black=0, white=0.
REQ-033 Board with cell 0 = 3'b111, cell 63 = 3'b110, rest 0 -> cell 0 state 10, cell 63 state 01 (x=7,y=7); black=1, white=1, empty=62.
REQ-034 cell_ack low for 5 cycles on cell 10 -> cell_index holds 10 for those cycles; counts unchanged until ack; totals still sum to 64.
REQ-035 Change curr_board to all 3'b111 and pulse start mid-scan -> start ignored, ready=0, totals reflect the original snapshot.
REQ-036 Assert reset at cell 30 -> next cycle cell_valid=0, ready=1, counts 0; new start then yields a full, correct 64-cell scan.
REQ-037 Cell 5 = 3'b010 -> cell_state 11 for cell 5; black+white+empty = 63 at done.

Source files
------------

// File: rtl/board_pkg.sv
// Shared board definitions: geometry, raw 3-bit cell codes and 2-bit decoded states.
package board_pkg;
  localparam int CELLS  = 64;
  localparam int CELL_W = 3;

  localparam logic [2:0] CELL_BLACK = 3'b111;
  localparam logic [2:0] CELL_WHITE = 3'b110;
  localparam logic [2:0] CELL_EMPTY = 3'b000;

  localparam logic [1:0] ST_EMPTY   = 2'b00;
  localparam logic [1:0] ST_WHITE   = 2'b01;
  localparam logic [1:0] ST_BLACK   = 2'b10;
  localparam logic [1:0] ST_ILLEGAL = 2'b11;
endpackage

// File: rtl/cell_decode.sv
// Combinational decode of one raw board cell code into its 2-bit state.
module cell_decode (
  input  logic [2:0] i_code,
  output logic [1:0] o_state
);
  import board_pkg::*;

  always_comb begin
    o_state = ST_ILLEGAL;
    case (i_code)
      CELL_EMPTY: o_state = ST_EMPTY;
      CELL_WHITE: o_state = ST_WHITE;
      CELL_BLACK: o_state = ST_BLACK;
      default:    o_state = ST_ILLEGAL;
    endcase
  end
endmodule

// File: rtl/board_reader.sv
// Scans a snapshot of the board one cell at a time over a valid/ack handshake,
// tallying black, white and empty cells for the scan.
module board_reader #(
  parameter int CELLS  = board_pkg::CELLS,
  parameter int CELL_W = board_pkg::CELL_W
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      start,
  input  logic [CELLS*CELL_W-1:0]   curr_board,
  output logic                      ready,
  output logic                      cell_valid,
  input  logic                      cell_ack,
  output logic [$clog2(CELLS)-1:0]  cell_index,
  output logic [2:0]                cell_x,
  output logic [2:0]                cell_y,
  output logic [1:0]                cell_state,
  output logic                      done,
  output logic [$clog2(CELLS):0]    black_count,
  output logic [$clog2(CELLS):0]    white_count,
  output logic [$clog2(CELLS):0]    empty_count
);
  import board_pkg::*;

  localparam int IDX_W = $clog2(CELLS);
  localparam int CNT_W = IDX_W + 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_SCAN = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t                    r_state;
  state_t                    w_next;
  logic [CELLS*CELL_W-1:0]   r_board;
  logic [IDX_W-1:0]          r_index;
  logic [CNT_W-1:0]          r_black;
  logic [CNT_W-1:0]          r_white;
  logic [CNT_W-1:0]          r_empty;
  logic [CELL_W-1:0]         w_code;
  logic [1:0]                w_state;
  logic                      w_accept;
  logic                      w_fire;
  logic                      w_last;

  assign w_code = r_board[int'(r_index)*CELL_W +: CELL_W];
  assign w_last = (r_index == IDX_W'(CELLS - 1));

  cell_decode u_decode (
    .i_code  (w_code),
    .o_state (w_state)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next   = r_state;
    w_accept = 1'b0;
    w_fire   = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (start) begin
          w_next   = S_SCAN;
          w_accept = 1'b1;
        end
      end
      S_SCAN: begin
        if (cell_ack) begin
          w_fire = 1'b1;
          if (w_last) w_next = S_DONE;
        end
      end
      S_DONE:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // Index stops at the last cell and only rewinds on the way back to idle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_board <= '0;
      r_index <= '0;
      r_black <= '0;
      r_white <= '0;
      r_empty <= '0;
    end else if (w_accept) begin
      r_board <= curr_board;
      r_index <= '0;
      r_black <= '0;
      r_white <= '0;
      r_empty <= '0;
    end else if (w_fire) begin
      if (!w_last) r_index <= r_index + IDX_W'(1);
      case (w_state)
        ST_BLACK: r_black <= r_black + CNT_W'(1);
        ST_WHITE: r_white <= r_white + CNT_W'(1);
        ST_EMPTY: r_empty <= r_empty + CNT_W'(1);
        default:  ;
      endcase
    end else if (r_state == S_DONE) begin
      r_index <= '0;
    end
  end

  assign ready       = (r_state == S_IDLE);
  assign cell_valid  = (r_state == S_SCAN);
  assign done        = (r_state == S_DONE);
  assign cell_index  = r_index;
  assign cell_x      = r_index[2:0];
  assign cell_y      = r_index[5:3];
  assign cell_state  = w_state;
  assign black_count = r_black;
  assign white_count = r_white;
  assign empty_count = r_empty;
endmodule

// File: tb/tb_board_reader.sv
// Randomized scoreboard bench for board_reader: expected cells and totals are
// queued at start, and a negedge monitor checks every accepted cell and done pulse.
module tb_board_reader;
  logic         clk = 1'b0;
  logic         reset;
  logic         start;
  logic [191:0] curr_board;
  logic         ready;
  logic         cell_valid;
  logic         cell_ack;
  logic [5:0]   cell_index;
  logic [2:0]   cell_x;
  logic [2:0]   cell_y;
  logic [1:0]   cell_state;
  logic         done;
  logic [6:0]   black_count;
  logic [6:0]   white_count;
  logic [6:0]   empty_count;

  board_reader #(.CELLS(64), .CELL_W(3)) dut (
    .clk         (clk),
    .reset       (reset),
    .start       (start),
    .curr_board  (curr_board),
    .ready       (ready),
    .cell_valid  (cell_valid),
    .cell_ack    (cell_ack),
    .cell_index  (cell_index),
    .cell_x      (cell_x),
    .cell_y      (cell_y),
    .cell_state  (cell_state),
    .done        (done),
    .black_count (black_count),
    .white_count (white_count),
    .empty_count (empty_count)
  );

  always #5 clk = ~clk;

  typedef struct { int idx; int st; } cell_t;
  typedef struct { int b; int w; int e; } tot_t;

  cell_t exp_q[$];
  tot_t  tot_q[$];
  int    checks = 0;
  int    errors = 0;
  int    exp_b, exp_w, exp_e;

  task automatic chk(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, req, $time);
    end
  endtask

  function automatic int ref_state(input logic [2:0] code);
    if (code == 3'b111) return 2;
    if (code == 3'b110) return 1;
    if (code == 3'b000) return 0;
    return 3;
  endfunction

  // Reference: enumerate all cells of the board and tally them.
  task automatic push_exp(input logic [191:0] b);
    cell_t c;
    tot_t  t;
    t = '{0, 0, 0};
    for (int i = 0; i < 64; i++) begin
      c.idx = i;
      c.st  = ref_state(b[3*i +: 3]);
      exp_q.push_back(c);
      if (c.st == 2) t.b++;
      else if (c.st == 1) t.w++;
      else if (c.st == 0) t.e++;
    end
    tot_q.push_back(t);
    exp_b = t.b; exp_w = t.w; exp_e = t.e;
  endtask

  function automatic logic [191:0] rand_board();
    logic [191:0] b;
    int r;
    for (int i = 0; i < 64; i++) begin
      r = int'($urandom_range(99));
      if (r < 40)      b[3*i +: 3] = 3'b000;
      else if (r < 65) b[3*i +: 3] = 3'b111;
      else if (r < 90) b[3*i +: 3] = 3'b110;
      else             b[3*i +: 3] = 3'($urandom_range(7));
    end
    return b;
  endfunction

  always @(negedge clk) begin
    cell_t c;
    tot_t  t;
    if (!reset) begin
      if (cell_valid && cell_ack) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_cell", 1, 0);
        end else begin
          c = exp_q.pop_front();
          chk("cell_index", int'(cell_index), c.idx);
          chk("cell_x", int'(cell_x), c.idx % 8);
          chk("cell_y", int'(cell_y), c.idx / 8);
          chk("cell_state", int'(cell_state), c.st);
        end
      end
      if (done) begin
        if (tot_q.size() == 0) begin
          chk("unexpected_done", 1, 0);
        end else begin
          t = tot_q.pop_front();
          chk("black_count", int'(black_count), t.b);
          chk("white_count", int'(white_count), t.w);
          chk("empty_count", int'(empty_count), t.e);
          chk("cells_left_at_done", exp_q.size(), 0);
        end
      end
    end
  end

  task automatic issue_start(input logic [191:0] b);
    int cyc = 0;
    while (!ready && cyc < 50) begin
      @(posedge clk); #1; cyc++;
    end
    chk("ready_before_start", int'(ready), 1);
    curr_board = b;
    start = 1'b1;
    push_exp(b);
    @(posedge clk); #1;
    start = 1'b0;
    chk("valid_after_start", int'(cell_valid), 1);
    chk("index_after_start", int'(cell_index), 0);
    chk("ready_in_scan", int'(ready), 0);
    chk("counts_clear", int'(black_count) + int'(white_count) + int'(empty_count), 0);
  endtask

  // mode: 0 plain, 1 stall on cell 10, 2 start mid-scan at cell 20, 3 reset at cell 30
  task automatic drive_scan(input int mode, input int ackpct);
    int cyc = 0;
    bit stalled = 0;
    bit glitched = 0;
    int sb, sw, se;
    while (1) begin
      if (done) break;
      if (cyc >= 3000) begin
        chk("scan_timeout", 1, 0);
        break;
      end
      chk("valid_in_scan", int'(cell_valid), 1);
      if (mode == 1 && cell_index == 6'd10 && !stalled) begin
        stalled = 1;
        cell_ack = 1'b0;
        sb = black_count; sw = white_count; se = empty_count;
        repeat (5) begin
          @(posedge clk); #1; cyc++;
          chk("stall_index", int'(cell_index), 10);
          chk("stall_counts", int'(black_count) + 100*int'(white_count) + 10000*int'(empty_count),
              sb + 100*sw + 10000*se);
        end
      end
      if (mode == 2 && cell_index == 6'd20 && !glitched) begin
        glitched = 1;
        curr_board = '1;
        start = 1'b1;
        chk("ready_mid_scan", int'(ready), 0);
      end
      if (mode == 3 && cell_index == 6'd30) begin
        cell_ack = 1'b0;
        reset = 1'b1;
        exp_q.delete();
        tot_q.delete();
        #1;
        chk("rst_valid", int'(cell_valid), 0);
        chk("rst_ready", int'(ready), 1);
        chk("rst_index", int'(cell_index), 0);
        chk("rst_done", int'(done), 0);
        chk("rst_counts", int'(black_count) + int'(white_count) + int'(empty_count), 0);
        @(posedge clk); #1;
        reset = 1'b0;
        return;
      end
      cell_ack = ($urandom_range(99) < ackpct);
      @(posedge clk); #1; cyc++;
      start = 1'b0;
    end
    cell_ack = 1'b0;
    chk("done_black", int'(black_count), exp_b);
    chk("done_sum", int'(black_count) + int'(white_count) + int'(empty_count), exp_b + exp_w + exp_e);
    @(posedge clk); #1;
    chk("done_pulse_width", int'(done), 0);
    chk("idle_ready", int'(ready), 1);
    chk("idle_index", int'(cell_index), 0);
    chk("hold_white", int'(white_count), exp_w);
    chk("hold_empty", int'(empty_count), exp_e);
  endtask

  initial begin
    logic [191:0] b;
    reset = 1'b1;
    start = 1'b1;
    cell_ack = 1'b0;
    curr_board = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_ready", int'(ready), 1);
    chk("reset_valid", int'(cell_valid), 0);
    chk("reset_done", int'(done), 0);
    chk("reset_index", int'(cell_index), 0);
    chk("reset_counts", int'(black_count) + int'(white_count) + int'(empty_count), 0);

    // All-empty board with start held through reset release.
    push_exp('0);
    reset = 1'b0;
    @(posedge clk); #1;
    start = 1'b0;
    chk("first_start_after_reset", int'(cell_valid), 1);
    drive_scan(0, 100);

    b = '0;
    b[2:0] = 3'b111;
    b[191:189] = 3'b110;
    issue_start(b);
    drive_scan(0, 100);

    issue_start(rand_board());
    drive_scan(1, 80);

    issue_start(rand_board());
    drive_scan(2, 70);

    issue_start(rand_board());
    drive_scan(3, 90);
    issue_start(rand_board());
    drive_scan(0, 100);

    b = '0;
    b[17:15] = 3'b010;
    issue_start(b);
    drive_scan(0, 60);

    b = '1;
    issue_start(b);
    drive_scan(0, 100);

    repeat (6) begin
      issue_start(rand_board());
      drive_scan(0, 50 + int'($urandom_range(50)));
    end

    repeat (2) @(posedge clk);
    #1;
    chk("cells_drained", exp_q.size(), 0);
    chk("totals_drained", tot_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not complete, expected finish before %0t", $time);
    $fatal(1);
  end
endmodule
